// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the unified memory port arbiter: requester IDs,
// FSM states and counter widths.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports plus the memory macro port.
// "master" is the environment (pipeline, debugger, memory); "slave" is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_W-1:0]     dbg_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_gnt, dm_rvalid, dm_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_gnt, dm_rvalid, dm_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Fixed-priority winner selection: DM > IF > DBG, except a starving IF beats DM.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic    i_ifReq,
  input  logic    i_dmReq,
  input  logic    i_dbgReq,
  input  logic    i_starve,
  output req_id_e o_winner
);

  always_comb begin
    o_winner = REQ_NONE;
    if (i_ifReq && (i_starve || !i_dmReq)) begin
      o_winner = REQ_IF;
    end else if (i_dmReq) begin
      o_winner = REQ_DM;
    end else if (i_dbgReq) begin
      o_winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by fetch, data stage and debug loader.
// One transaction in flight; arbitration happens in IDLE and in RESP for back-to-back issue.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [LAT_CNT_W-1:0]    LAT_LAST   = LAT_CNT_W'(MEM_LATENCY);
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e                r_state;
  arb_state_e                w_nextState;
  req_id_e                   r_owner;
  req_id_e                   w_pick;
  req_id_e                   w_winner;
  logic [LAT_CNT_W-1:0]      r_latCnt;
  logic [STARVE_CNT_W-1:0]   r_starveCnt;
  logic                      r_isWrite;
  logic [DATA_W-1:0]         r_ifRdata;
  logic [DATA_W-1:0]         r_dmRdata;
  logic [DATA_W-1:0]         r_dbgRdata;
  logic                      w_arbActive;
  logic                      w_starve;
  logic                      w_grant;
  logic                      w_latDone;

  assign w_starve = (r_starveCnt == STARVE_MAX);

  mem_arb_pick u_pick (
    .i_ifReq  (bus.if_req),
    .i_dmReq  (bus.dm_req),
    .i_dbgReq (bus.dbg_req),
    .i_starve (w_starve),
    .o_winner (w_pick)
  );

  // Grants are combinational, so they are masked while reset is held.
  assign w_arbActive = !reset && ((r_state == IDLE) || (r_state == RESP));
  assign w_winner    = w_arbActive ? w_pick : REQ_NONE;
  assign w_grant     = (w_winner != REQ_NONE);
  assign w_latDone   = (r_state == WAIT) && (r_latCnt == LAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, RESP: w_nextState = w_grant ? WAIT : IDLE;
      WAIT:       w_nextState = w_latDone ? RESP : WAIT;
      default:    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt     = (w_winner == REQ_IF);
    bus.dm_gnt     = (w_winner == REQ_DM);
    bus.dbg_gnt    = (w_winner == REQ_DBG);
    bus.mem_en     = w_grant;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_be     = '0;
    unique case (w_winner)
      REQ_IF: begin
        bus.mem_addr = bus.if_addr;
        bus.mem_be   = '1;
      end
      REQ_DM: begin
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
        bus.mem_be    = bus.dm_be;
      end
      REQ_DBG: begin
        bus.mem_we    = bus.dbg_we;
        bus.mem_addr  = bus.dbg_addr;
        bus.mem_wdata = bus.dbg_wdata;
        bus.mem_be    = '1;
      end
      default: ;
    endcase
    bus.if_rvalid  = (r_state == RESP) && (r_owner == REQ_IF);
    bus.dm_rvalid  = (r_state == RESP) && (r_owner == REQ_DM);
    bus.dbg_rvalid = (r_state == RESP) && (r_owner == REQ_DBG);
    bus.busy       = (r_state == WAIT) || w_grant;
  end

  assign bus.if_rdata  = r_ifRdata;
  assign bus.dm_rdata  = r_dmRdata;
  assign bus.dbg_rdata = r_dbgRdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= REQ_NONE;
      r_latCnt    <= '0;
      r_isWrite   <= 1'b0;
      r_starveCnt <= '0;
      r_ifRdata   <= '0;
      r_dmRdata   <= '0;
      r_dbgRdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_winner;
        r_latCnt  <= LAT_CNT_W'(1);
        r_isWrite <= bus.mem_we;
      end else if ((r_state == WAIT) && !w_latDone) begin
        r_latCnt <= r_latCnt + LAT_CNT_W'(1);
      end

      // Writes complete with zero data so rvalid never exposes stale bus values.
      if (w_latDone) begin
        unique case (r_owner)
          REQ_IF:  r_ifRdata  <= r_isWrite ? '0 : bus.mem_rdata;
          REQ_DM:  r_dmRdata  <= r_isWrite ? '0 : bus.mem_rdata;
          REQ_DBG: r_dbgRdata <= r_isWrite ? '0 : bus.mem_rdata;
          default: ;
        endcase
      end

      if (w_winner == REQ_IF) begin
        r_starveCnt <= '0;
      end else if (w_arbActive && bus.if_req && !w_starve) begin
        r_starveCnt <= r_starveCnt + STARVE_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory of fixed read latency.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_LATENCY (MEM_LATENCY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears MEM_LATENCY cycles after the issuing edge.
  logic [31:0] mem [0:63];
  logic [31:0] rdPipe [0:MEM_LATENCY-1];

  always @(posedge clk) begin
    logic [31:0] word;
    if (bus.mem_en && bus.mem_we) begin
      word = mem[bus.mem_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
      mem[bus.mem_addr[7:2]] = word;
    end
    rdPipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]] : 32'hDEADBEEF;
    for (int s = 1; s < MEM_LATENCY; s++) rdPipe[s] <= rdPipe[s-1];
  end

  assign bus.mem_rdata = rdPipe[MEM_LATENCY-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of requester inputs shortly after the edge, then settles.
  task automatic applyStimulus(
    input logic        ifReq,  input logic [31:0] ifAddr,
    input logic        dmReq,  input logic        dmWe,
    input logic [31:0] dmAddr, input logic [31:0] dmWdata, input logic [3:0] dmBe,
    input logic        dbgReq, input logic        dbgWe,
    input logic [31:0] dbgAddr, input logic [31:0] dbgWdata
  );
    @(posedge clk);
    #2;
    bus.if_req    = ifReq;
    bus.if_addr   = ifAddr;
    bus.dm_req    = dmReq;
    bus.dm_we     = dmWe;
    bus.dm_addr   = dmAddr;
    bus.dm_wdata  = dmWdata;
    bus.dm_be     = dmBe;
    bus.dbg_req   = dbgReq;
    bus.dbg_we    = dbgWe;
    bus.dbg_addr  = dbgAddr;
    bus.dbg_wdata = dbgWdata;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.if_req    = 0; bus.if_addr  = 0;
    bus.dm_req    = 0; bus.dm_we    = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    bus.dbg_req   = 0; bus.dbg_we   = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[2] = 32'h00500113;
    mem[4] = 32'h11112222;

    // Reset: a pending request must not produce a grant while reset is held.
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_if_gnt", {31'b0, bus.if_gnt}, 0);
    checkOutput("rst_mem_en", {31'b0, bus.mem_en}, 0);
    checkOutput("rst_busy",   {31'b0, bus.busy},   0);
    idleCycle();
    reset = 1'b0;
    checkOutput("rst_if_rdata",  bus.if_rdata,  0);
    checkOutput("rst_dm_rdata",  bus.dm_rdata,  0);
    checkOutput("rst_dbg_rdata", bus.dbg_rdata, 0);
    for (int i = 0; i < 20; i++) begin
      idleCycle();
      checkOutput("idle_mem_en", {31'b0, bus.mem_en}, 0);
      checkOutput("idle_busy",   {31'b0, bus.busy},   0);
      checkOutput("idle_flags", {26'b0, bus.if_gnt, bus.dm_gnt, bus.dbg_gnt,
                                 bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid}, 0);
    end

    // Single IF read of 0x8
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("if1_gnt",    {31'b0, bus.if_gnt}, 1);
    checkOutput("if1_mem_en", {31'b0, bus.mem_en}, 1);
    checkOutput("if1_addr",   bus.mem_addr, 32'h8);
    checkOutput("if1_we",     {31'b0, bus.mem_we}, 0);
    checkOutput("if1_busy",   {31'b0, bus.busy}, 1);
    idleCycle();
    checkOutput("if1_w1_en",  {31'b0, bus.mem_en}, 0);
    checkOutput("if1_w1_busy",{31'b0, bus.busy}, 1);
    idleCycle();
    checkOutput("if1_w2_rv",  {31'b0, bus.if_rvalid}, 0);
    idleCycle();
    checkOutput("if1_rvalid", {31'b0, bus.if_rvalid}, 1);
    checkOutput("if1_rdata",  bus.if_rdata, 32'h00500113);
    checkOutput("if1_r_busy", {31'b0, bus.busy}, 0);
    idleCycle();
    checkOutput("if1_rv_off", {31'b0, bus.if_rvalid}, 0);
    checkOutput("if1_hold",   bus.if_rdata, 32'h00500113);

    // Contention: DM first, IF on the RESP-cycle arbitration
    applyStimulus(1, 32'h8, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);
    checkOutput("ct_gnts",  {29'b0, bus.if_gnt, bus.dm_gnt, bus.dbg_gnt}, 3'b010);
    checkOutput("ct_addr",  bus.mem_addr, 32'h10);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ct_w1_gnts", {29'b0, bus.if_gnt, bus.dm_gnt, bus.dbg_gnt}, 0);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ct_w2_en", {31'b0, bus.mem_en}, 0);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ct_dm_rvalid", {31'b0, bus.dm_rvalid}, 1);
    checkOutput("ct_dm_rdata",  bus.dm_rdata, 32'h11112222);
    checkOutput("ct_gnts2", {29'b0, bus.if_gnt, bus.dm_gnt, bus.dbg_gnt}, 3'b100);
    checkOutput("ct_addr2", bus.mem_addr, 32'h8);
    checkOutput("ct_if_rv", {31'b0, bus.if_rvalid}, 0);
    checkOutput("ct_busy",  {31'b0, bus.busy}, 1);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("ct_if_rvalid", {31'b0, bus.if_rvalid}, 1);
    checkOutput("ct_if_rdata",  bus.if_rdata, 32'h00500113);
    checkOutput("ct_dm_rv_off", {31'b0, bus.dm_rvalid}, 0);

    // Starvation: DM wins four times, IF forced on the fifth, DM resumes
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 32'h8, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);
      checkOutput($sformatf("sv%0d_dm_gnt", k), {31'b0, bus.dm_gnt}, {31'b0, (k != 4)});
      checkOutput($sformatf("sv%0d_if_gnt", k), {31'b0, bus.if_gnt}, {31'b0, (k == 4)});
      checkOutput($sformatf("sv%0d_if_rv", k),  {31'b0, bus.if_rvalid}, {31'b0, (k == 5)});
      checkOutput($sformatf("sv%0d_dm_rv", k),  {31'b0, bus.dm_rvalid},
                  {31'b0, (k >= 1 && k != 5)});
      applyStimulus(1, 32'h8, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);
      checkOutput($sformatf("sv%0d_wait_en", k), {31'b0, bus.mem_en}, 0);
      applyStimulus(1, 32'h8, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);
    end
    idleCycle();
    checkOutput("sv_last_dm_rv", {31'b0, bus.dm_rvalid}, 1);
    checkOutput("sv_last_busy",  {31'b0, bus.busy}, 0);

    // Debug read, then a back-to-back debug write of 0x002081b3 to 0x8
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
    checkOutput("dbgr_gnt", {31'b0, bus.dbg_gnt}, 1);
    checkOutput("dbgr_be",  {28'b0, bus.mem_be}, 4'hF);
    idleCycle();
    idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 32'h002081b3);
    checkOutput("dbgr_rvalid", {31'b0, bus.dbg_rvalid}, 1);
    checkOutput("dbgr_rdata",  bus.dbg_rdata, 32'h11112222);
    checkOutput("dbgw_gnt",    {31'b0, bus.dbg_gnt}, 1);
    checkOutput("dbgw_we",     {31'b0, bus.mem_we}, 1);
    checkOutput("dbgw_be",     {28'b0, bus.mem_be}, 4'hF);
    checkOutput("dbgw_wdata",  bus.mem_wdata, 32'h002081b3);
    checkOutput("dbgw_addr",   bus.mem_addr, 32'h8);
    idleCycle();
    idleCycle();
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dbgw_rvalid", {31'b0, bus.dbg_rvalid}, 1);
    checkOutput("dbgw_rdata",  bus.dbg_rdata, 0);
    checkOutput("if2_gnt",     {31'b0, bus.if_gnt}, 1);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("if2_rvalid", {31'b0, bus.if_rvalid}, 1);
    checkOutput("if2_rdata",  bus.if_rdata, 32'h002081b3);

    // Async reset one cycle after a DM grant drops the transaction
    applyStimulus(0, 0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0);
    checkOutput("ar_dm_gnt", {31'b0, bus.dm_gnt}, 1);
    idleCycle();
    reset = 1'b1;
    #1;
    checkOutput("ar_busy",     {31'b0, bus.busy}, 0);
    checkOutput("ar_mem_en",   {31'b0, bus.mem_en}, 0);
    checkOutput("ar_dm_rdata", bus.dm_rdata, 0);
    idleCycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput("ar_no_rvalid", {29'b0, bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid}, 0);
    end
    applyStimulus(0, 0, 1, 1, 32'h10, 32'hAABBCCDD, 4'b0011, 0, 0, 0, 0);
    checkOutput("ar_w_gnt",   {31'b0, bus.dm_gnt}, 1);
    checkOutput("ar_w_we",    {31'b0, bus.mem_we}, 1);
    checkOutput("ar_w_be",    {28'b0, bus.mem_be}, 4'b0011);
    checkOutput("ar_w_wdata", bus.mem_wdata, 32'hAABBCCDD);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("ar_w_rvalid", {31'b0, bus.dm_rvalid}, 1);
    checkOutput("ar_w_rdata",  bus.dm_rdata, 0);
    idleCycle();
    checkOutput("ar_mem_merge", mem[4], 32'h1111CCDD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the 5-stage pipeline CPU between three requesters: instruction fetch (IF), data memory stage (DM) and the debug/program loader (DBG).
- Sequences one memory transaction at a time, generates grants and read-return pulses, and guarantees IF forward progress under sustained DM traffic.
- Sits between the pipeline's IF/MEM stages and the memory macro; the pipeline stalls on missing grant.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from mem_en issue to valid mem_rdata; legal range 1..7.
- STARVE_LIMIT, 4, consecutive lost arbitrations by IF before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle grant.
- if_rvalid  out  1  one-cycle read-data valid.
- if_rdata  out  DATA_W  fetched word.
- dm_req, dm_we  in  1  data request / write enable.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_be  in  DATA_W/8  byte enables.
- dm_gnt, dm_rvalid  out  1  grant / completion.
- dm_rdata  out  DATA_W  load data.
- dbg_req, dbg_we  in  1  debug request / write enable.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data; byte enables forced all-ones.
- dbg_gnt, dbg_rvalid  out  1  grant / completion.
- dbg_rdata  out  DATA_W  debug read data.
- mem_en, mem_we  out  1  memory strobe / write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction outstanding.

Behaviour:
- Reset: all outputs 0. State goes to IDLE, starvation counter to 0, owner to none. Reset mid-transaction drops it; no rvalid is ever produced for it.
- FSM states:
  - IDLE: arbitrate.
  - WAIT: count MEM_LATENCY cycles.
  - RESP: pulse rvalid.
- IDLE, cycle N, any req high:
  - Pick a winner.
  - Assert the winner's gnt and mem_en combinationally in cycle N.
  - Drive mem_we/addr/wdata/be from the winner.
  - Latch the owner and go to WAIT.
  - No req high: stay in IDLE with mem_en=0.
- Priority: DM > IF > DBG. Exception: when the starvation counter equals STARVE_LIMIT, IF beats DM.
- Starvation counter:
  - Increments on an IDLE arbitration cycle where if_req=1 and IF loses.
  - Clears on if_gnt.
  - Saturates at STARVE_LIMIT.
  - DBG has no progress guarantee.
- WAIT: counter runs MEM_LATENCY cycles. In cycle N+MEM_LATENCY, register mem_rdata into the owner's rdata, then go to RESP.
- RESP, cycle N+MEM_LATENCY+1:
  - Owner's rvalid=1 for exactly one cycle.
  - Writes also pulse rvalid, with rdata=0.
  - The arbitration of IDLE is also performed in RESP (back-to-back issue allowed). RESP goes to WAIT if there is a grant, else to IDLE.
  - Peak throughput is one transaction per MEM_LATENCY+1 cycles.
- rdata of non-owners holds its last value. Only rvalid qualifies data.
- Requester handshake:
  - A requester may drop req before gnt with no effect.
  - Changing addr/we while req is high and gnt is low is permitted; the values sampled in the gnt cycle win.
- busy=1 in WAIT, and in RESP or IDLE when a grant is issued that cycle.
- At most one gnt per cycle and at most one rvalid per cycle. mem_en is never asserted in WAIT.

Decomposition:
- Package cpu_mem_pkg holds:
  - Requester ID encoding: REQ_NONE=0, REQ_IF=1, REQ_DM=2, REQ_DBG=3.
  - FSM state encoding: IDLE, WAIT, RESP.
  - Latency counter width constant (3 bits).
  - Starvation counter width constant (4 bits).
- One combinational sub-module, mem_arb_pick: inputs are the three reqs and the starve flag; output is the winner ID.
- The FSM, counters and muxes stay in mem_port_arbiter.

Test Plan:
- Reset: reset=1 for 2 cycles then release, no reqs -> all outputs 0, busy=0, mem_en never high for 20 cycles.
- Single IF read: if_req at 0x00000008, mem returns 0x00500113 -> if_gnt and mem_en in the same cycle; if_rvalid exactly 3 cycles later with if_rdata=0x00500113.
- Contention: if_req and dm_req both high in IDLE -> dm_gnt first; if_gnt on the next arbitration 3 cycles later; never two gnts in one cycle.
- Starvation: dm_req held high continuously with if_req high -> DM wins 4 arbitrations, then IF wins the 5th; the counter then clears and DM resumes.
- Debug load: dbg_we=1 writing 0x002081b3 to 0x8 while IF/DM are idle -> mem_we=1, mem_be=0xF; dbg_rvalid pulses with dbg_rdata=0. A later IF read of 0x8 returns 0x002081b3.
- Async reset mid-WAIT: assert reset one cycle after dm_gnt -> outputs 0 immediately; no dm_rvalid after release; the next request is served normally.
